// File: rtl/arm_hazard_pkg.sv
// Shared types for the ARM pipeline hazard unit.
//   fwd_sel_t   : execute operand source select (register file / ResultW / ALUOutM)
//   stage_tag_t : shadow copy of what an in-flight instruction writes and reads
//   tag_match   : RAW match of a source register against one stage tag
package arm_hazard_pkg;

  // Tag address fields are stored at a fixed width. Narrower register
  // addresses are zero-extended into them, so REG_ADDR_W may be 1..8.
  localparam int TAG_ADDR_W = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] wa3;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  memaccess;
    logic                  pcwrite;
    logic [TAG_ADDR_W-1:0] ra1;
    logic [TAG_ADDR_W-1:0] ra2;
  } stage_tag_t;

  // The PC alias is never a data hazard: it is read from the PC path.
  function automatic logic tag_match(
    input stage_tag_t            tag,
    input logic [TAG_ADDR_W-1:0] src,
    input logic [TAG_ADDR_W-1:0] pc_reg
  );
    return tag.valid && tag.regwrite && (tag.wa3 == src) && (src != pc_reg);
  endfunction

endpackage

// File: rtl/arm_hazard_unit_tag_pipe.sv
// Shadow E/M/W tag registers mirroring the core pipeline registers.
//   clk, reset   : core clock, asynchronous active-high reset
//   i_d_tag      : tag built from the decode-stage instruction
//   i_bubble_e   : load a bubble (valid=0) into E instead of the D tag
//   i_hold       : memory wait; E and M hold, W receives a bubble
//   o_e/m/w_tag  : current tags of the execute, memory and writeback stages
module hazard_tag_pipe
  import arm_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  stage_tag_t i_d_tag,
  input  logic       i_bubble_e,
  input  logic       i_hold,
  output stage_tag_t o_e_tag,
  output stage_tag_t o_m_tag,
  output stage_tag_t o_w_tag
);

  stage_tag_t r_e;
  stage_tag_t r_m;
  stage_tag_t r_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (i_hold) begin
      // The access in M has not completed, so nothing retires into W.
      r_w.valid <= 1'b0;
    end else begin
      r_e       <= i_d_tag;
      r_e.valid <= i_d_tag.valid && !i_bubble_e;
      r_m       <= r_e;
      r_w       <= r_m;
    end
  end

  assign o_e_tag = r_e;
  assign o_m_tag = r_m;
  assign o_w_tag = r_w;

endmodule

// File: rtl/arm_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage ARM pipeline.
//   clk, reset             : core clock, asynchronous active-high reset
//   RA1D/RA2D/WA3D         : decode source A/B and destination registers
//   RegWriteD/MemToRegD/MemAccessD : decode instruction class
//   BranchTakenE           : branch resolved taken in execute
//   mem_ready              : data memory completes the M-stage access
//   perf_clear             : synchronous clear of both perf counters
//   ForwardAE/ForwardBE    : execute operand selects (00 RF, 01 ResultW, 10 ALUOutM)
//   StallF/D/E/M           : hold PC and the F/D, D/E, E/M registers
//   FlushD/E/W             : bubble into D, E, W
//   stall_cycles           : saturating count of cycles with StallF
//   flush_events           : saturating count of cycles with FlushE
module arm_hazard_unit
  import arm_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15,
  parameter bit FWD_ENABLE = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] WA3D,
  input  logic                  RegWriteD,
  input  logic                  MemToRegD,
  input  logic                  MemAccessD,
  input  logic                  BranchTakenE,
  input  logic                  mem_ready,
  input  logic                  perf_clear,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam logic [TAG_ADDR_W-1:0] PC_TAG = TAG_ADDR_W'(PC_REG);

  stage_tag_t            w_d_tag;
  stage_tag_t            w_e_tag;
  stage_tag_t            w_m_tag;
  stage_tag_t            w_w_tag;
  logic [TAG_ADDR_W-1:0] w_d_src [2];
  logic [TAG_ADDR_W-1:0] w_e_src [2];
  logic [1:0]            w_d_hit_e;
  logic [1:0]            w_d_hit_m;
  fwd_sel_t              w_fwd [2];
  logic                  w_ldr_stall;
  logic                  w_raw_stall;
  logic                  w_pc_pend;
  logic                  w_mem_stall;
  logic [CNT_W-1:0]      w_cnt [2];
  logic [1:0]            w_cnt_inc;
  logic                  w_unused_tag_bits;

  always_comb begin
    w_d_tag           = '0;
    w_d_tag.valid     = 1'b1;
    w_d_tag.wa3       = TAG_ADDR_W'(WA3D);
    w_d_tag.regwrite  = RegWriteD;
    w_d_tag.memtoreg  = MemToRegD;
    w_d_tag.memaccess = MemAccessD;
    w_d_tag.pcwrite   = RegWriteD && (TAG_ADDR_W'(WA3D) == PC_TAG);
    w_d_tag.ra1       = TAG_ADDR_W'(RA1D);
    w_d_tag.ra2       = TAG_ADDR_W'(RA2D);
  end

  hazard_tag_pipe u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_d_tag    (w_d_tag),
    .i_bubble_e (FlushE),
    .i_hold     (w_mem_stall),
    .o_e_tag    (w_e_tag),
    .o_m_tag    (w_m_tag),
    .o_w_tag    (w_w_tag)
  );

  assign w_d_src[0] = w_d_tag.ra1;
  assign w_d_src[1] = w_d_tag.ra2;
  assign w_e_src[0] = w_e_tag.ra1;
  assign w_e_src[1] = w_e_tag.ra2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign w_d_hit_e[gi] = tag_match(w_e_tag, w_d_src[gi], PC_TAG);
      assign w_d_hit_m[gi] = tag_match(w_m_tag, w_d_src[gi], PC_TAG);
      if (FWD_ENABLE) begin : g_fwd
        // A bubble in E has no operands, so it never selects a bypass.
        assign w_fwd[gi] = !w_e_tag.valid                          ? FWD_RF :
                           tag_match(w_m_tag, w_e_src[gi], PC_TAG) ? FWD_M  :
                           tag_match(w_w_tag, w_e_src[gi], PC_TAG) ? FWD_W  :
                                                                     FWD_RF;
      end else begin : g_no_fwd
        assign w_fwd[gi] = FWD_RF;
      end
    end
  endgenerate

  assign ForwardAE = w_fwd[0];
  assign ForwardBE = w_fwd[1];

  assign w_ldr_stall = w_e_tag.valid && w_e_tag.memtoreg && (|w_d_hit_e);
  // Without bypasses, any producer still in E or M must reach W first.
  assign w_raw_stall = !FWD_ENABLE && ((|w_d_hit_e) || (|w_d_hit_m));
  assign w_pc_pend   = w_d_tag.pcwrite
                    || (w_e_tag.valid && w_e_tag.pcwrite)
                    || (w_m_tag.valid && w_m_tag.pcwrite);
  assign w_mem_stall = w_m_tag.valid && w_m_tag.memaccess && !mem_ready;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      // E is frozen, so a pending branch or load-use is re-evaluated on release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_ldr_stall || w_raw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (w_pc_pend) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
      // The fetch after a PC write in W is from the stale PC.
      if (w_w_tag.valid && w_w_tag.pcwrite) begin
        FlushD = 1'b1;
      end
    end
  end

  assign w_cnt_inc[0] = StallF;
  assign w_cnt_inc[1] = FlushE;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_counter
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (perf_clear) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign stall_cycles = w_cnt[0];
  assign flush_events = w_cnt[1];

  // Not every tag field is consumed in every stage.
  assign w_unused_tag_bits = ^{w_e_tag, w_m_tag, w_w_tag};

endmodule

// File: tb/tb_arm_hazard_unit.sv
module tb_arm_hazard_unit;

  // control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LDR  = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_PC   = 7'b1000100;
  localparam logic [6:0] C_FDW  = 7'b0000100;

  typedef struct {
    int          dut;
    logic [10:0] ctl;
    bit          chk_cnt;
    logic [15:0] sc;
    logic [15:0] fc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ra1d = '0, ra2d = '0, wa3d = '0;
  logic       rwd = 1'b0, m2rd = 1'b0, mad = 1'b0;
  logic       br_e = 1'b0, mem_ready = 1'b1, perf_clear = 1'b0;

  logic [1:0] fae [3];
  logic [1:0] fbe [3];
  logic       sf [3], sd [3], se [3], sm [3], fd [3], fe [3], fw [3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  always #5 clk = ~clk;

  arm_hazard_unit u_dut0 (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d),
    .RegWriteD(rwd), .MemToRegD(m2rd), .MemAccessD(mad), .BranchTakenE(br_e),
    .mem_ready(mem_ready), .perf_clear(perf_clear),
    .ForwardAE(fae[0]), .ForwardBE(fbe[0]), .StallF(sf[0]), .StallD(sd[0]),
    .StallE(se[0]), .StallM(sm[0]), .FlushD(fd[0]), .FlushE(fe[0]), .FlushW(fw[0]),
    .stall_cycles(sc0), .flush_events(fc0));

  arm_hazard_unit #(.FWD_ENABLE(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d),
    .RegWriteD(rwd), .MemToRegD(m2rd), .MemAccessD(mad), .BranchTakenE(br_e),
    .mem_ready(mem_ready), .perf_clear(perf_clear),
    .ForwardAE(fae[1]), .ForwardBE(fbe[1]), .StallF(sf[1]), .StallD(sd[1]),
    .StallE(se[1]), .StallM(sm[1]), .FlushD(fd[1]), .FlushE(fe[1]), .FlushW(fw[1]),
    .stall_cycles(sc1), .flush_events(fc1));

  arm_hazard_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d),
    .RegWriteD(rwd), .MemToRegD(m2rd), .MemAccessD(mad), .BranchTakenE(br_e),
    .mem_ready(mem_ready), .perf_clear(perf_clear),
    .ForwardAE(fae[2]), .ForwardBE(fbe[2]), .StallF(sf[2]), .StallD(sd[2]),
    .StallE(se[2]), .StallM(sm[2]), .FlushD(fd[2]), .FlushE(fe[2]), .FlushW(fw[2]),
    .stall_cycles(sc2), .flush_events(fc2));

  function automatic logic [10:0] got_ctl(input int d);
    return {fae[d], fbe[d], sf[d], sd[d], se[d], sm[d], fd[d], fe[d], fw[d]};
  endfunction

  function automatic logic [15:0] got_sc(input int d);
    case (d)
      0:       return sc0;
      1:       return sc1;
      default: return {14'd0, sc2};
    endcase
  endfunction

  function automatic logic [15:0] got_fc(input int d);
    case (d)
      0:       return fc0;
      1:       return fc1;
      default: return {14'd0, fc2};
    endcase
  endfunction

  // Monitor: outputs are combinational and presented every cycle; compare
  // whatever the stimulus queued for this cycle (or for an async event).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (got_ctl(e.dut) !== e.ctl) begin
          n_bad++;
          $display("FAIL %s dut%0d ctl {fa,fb,sF,sD,sE,sM,fD,fE,fW}: got %b want %b",
                   e.name, e.dut, got_ctl(e.dut), e.ctl);
        end else begin
          $display("ok   %s dut%0d ctl %b", e.name, e.dut, e.ctl);
        end
        if (e.chk_cnt) begin
          n_cmp++;
          if (got_sc(e.dut) !== e.sc || got_fc(e.dut) !== e.fc) begin
            n_bad++;
            $display("FAIL %s dut%0d counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.name, e.dut, got_sc(e.dut), got_fc(e.dut), e.sc, e.fc);
          end else begin
            $display("ok   %s dut%0d counters stall=%0d flush=%0d", e.name, e.dut, e.sc, e.fc);
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                       input logic rw, input logic m2r, input logic ma,
                       input logic br, input logic mr);
    @(posedge clk);
    #1;
    ra1d = a1; ra2d = a2; wa3d = wa;
    rwd = rw; m2rd = m2r; mad = ma;
    br_e = br; mem_ready = mr;
  endtask

  task automatic nop();
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_out(input int d, input string name, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [6:0] c);
    exp_t e;
    e.dut = d; e.ctl = {fa, fb, c}; e.chk_cnt = 1'b0; e.sc = '0; e.fc = '0; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_cnt(input int d, input string name, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [6:0] c,
                            input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.dut = d; e.ctl = {fa, fb, c}; e.chk_cnt = 1'b1; e.sc = sc; e.fc = fc; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) expect_cnt(d, "reset", 2'b00, 2'b00, C_NONE, 16'd0, 16'd0);

    // forwarding from M and W
    drive(4'd5, 4'd6, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); reset = 1'b0;
    expect_out(0, "add_r1_in_d", 2'b00, 2'b00, C_NONE);
    drive(4'd1, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "reader_in_d", 2'b00, 2'b00, C_NONE);
    drive(4'd9, 4'd1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "fwd_a_from_m", 2'b10, 2'b00, C_NONE);
    drive(4'd10, 4'd8, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "fwd_b_from_w", 2'b00, 2'b01, C_NONE);
    drive(4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "fwd_a_m_b_w", 2'b10, 2'b01, C_NONE);
    nop();
    expect_out(0, "m_over_w", 2'b10, 2'b00, C_NONE);
    nop();
    nop();

    // load-use stall
    drive(4'd3, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, "ldr_in_d", 2'b00, 2'b00, C_NONE);
    drive(4'd4, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "ldr_stall", 2'b00, 2'b00, C_LDR);
    drive(4'd4, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_cnt(0, "ldr_release", 2'b00, 2'b00, C_NONE, 16'd1, 16'd1);
    nop();
    expect_out(0, "ldr_fwd_w", 2'b00, 2'b01, C_NONE);

    // branch beats load-use
    drive(4'd3, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, "ldr2_in_d", 2'b00, 2'b00, C_NONE);
    drive(4'd2, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out(0, "branch_over_ldr", 2'b00, 2'b00, C_BR);
    nop();
    expect_cnt(0, "after_branch", 2'b00, 2'b00, C_NONE, 16'd1, 16'd2);

    // memory wait with a pending branch
    drive(4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_out(0, "ldr7_in_d", 2'b00, 2'b00, C_NONE);
    nop();
    expect_out(0, "ldr7_in_e", 2'b00, 2'b00, C_NONE);
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "mem_wait", 2'b00, 2'b00, C_MEM);
    end
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_cnt(0, "mem_release_branch", 2'b00, 2'b00, C_BR, 16'd4, 16'd2);
    nop();
    expect_cnt(0, "after_mem", 2'b00, 2'b00, C_NONE, 16'd4, 16'd3);

    // PC write tracked through D/E/M/W; PC reads never forward
    drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "pc_in_d", 2'b00, 2'b00, C_PC);
    drive(4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(0, "pc_in_e", 2'b00, 2'b00, C_PC);
    nop();
    expect_out(0, "pc_in_m_no_fwd", 2'b00, 2'b00, C_PC);
    nop();
    expect_out(0, "pc_in_w", 2'b00, 2'b00, C_FDW);
    nop();
    expect_cnt(0, "pc_done", 2'b00, 2'b00, C_NONE, 16'd7, 16'd3);
    expect_cnt(2, "saturate", 2'b00, 2'b00, C_NONE, 16'd3, 16'd3);

    // perf_clear wins over a concurrent increment
    drive(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); perf_clear = 1'b1;
    expect_out(0, "pc_with_clear", 2'b00, 2'b00, C_PC);
    nop(); perf_clear = 1'b0;
    expect_cnt(0, "cleared", 2'b00, 2'b00, C_PC, 16'd0, 16'd0);
    expect_cnt(2, "cleared_sat", 2'b00, 2'b00, C_PC, 16'd0, 16'd0);
    nop();
    expect_cnt(0, "count_after_clear", 2'b00, 2'b00, C_PC, 16'd1, 16'd0);
    nop();
    expect_cnt(0, "pc2_in_w", 2'b00, 2'b00, C_FDW, 16'd2, 16'd0);

    // re-align all instances, then the no-forwarding configuration
    nop(); reset = 1'b1;
    for (int d = 0; d < 3; d++) expect_cnt(d, "reset2", 2'b00, 2'b00, C_NONE, 16'd0, 16'd0);
    drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); reset = 1'b0;
    expect_out(1, "nofwd_add_r3", 2'b00, 2'b00, C_NONE);
    drive(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(1, "nofwd_stall_e", 2'b00, 2'b00, C_LDR);
    expect_out(0, "fwd_no_stall", 2'b00, 2'b00, C_NONE);
    drive(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(1, "nofwd_stall_m", 2'b00, 2'b00, C_LDR);
    expect_out(0, "fwd_from_m", 2'b10, 2'b00, C_NONE);
    drive(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_cnt(1, "nofwd_release", 2'b00, 2'b00, C_NONE, 16'd2, 16'd2);
    drive(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(1, "nofwd_add_r3_again", 2'b00, 2'b00, C_NONE);
    drive(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out(1, "nofwd_stall_again", 2'b00, 2'b00, C_LDR);

    // asynchronous reset in the middle of the stall, away from any clock edge
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    expect_cnt(1, "async_reset", 2'b00, 2'b00, C_NONE, 16'd0, 16'd0);
    expect_cnt(0, "async_reset", 2'b00, 2'b00, C_NONE, 16'd0, 16'd0);
    -> chk_now;
    #1 reset = 1'b0;
    nop();
    expect_cnt(1, "after_async_reset", 2'b00, 2'b00, C_NONE, 16'd0, 16'd0);

    repeat (5) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_hazard_unit.md
Name: arm_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined ARM core (fetch/decode/execute/memory/writeback). It tracks destination tags of in-flight instructions in an internal shadow pipeline, so stages no longer carry WA3 by hand. From those tags it drives ForwardAE/BE, stall and flush per stage, and memory-wait stalls. It replaces the constant pipeEnable/pcEnable/ForwardAE/ForwardBE tie-offs at the core top level and adds saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 4, register address width
PC_REG, 15, register index aliased to PC; reads of it never hazard, writes of it are PC writes
FWD_ENABLE, 1, 1 = forward from M/W; 0 = no forwarding, stall on any RAW against E or M
CNT_W, 16, perf counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
RA1D  in  REG_ADDR_W  decode source register A
RA2D  in  REG_ADDR_W  decode source register B
WA3D  in  REG_ADDR_W  decode destination register
RegWriteD  in  1  decode instruction writes the register file
MemToRegD  in  1  decode instruction is a load
MemAccessD  in  1  decode instruction is a load or store
BranchTakenE  in  1  branch resolved taken in execute
mem_ready  in  1  data memory completes the current M-stage access
perf_clear  in  1  synchronous clear of both counters
ForwardAE  out  2  execute operand A select: 00 register file, 01 ResultW, 10 ALUOutM
ForwardBE  out  2  execute operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  bubble into D
FlushE  out  1  bubble into E
FlushW  out  1  bubble into W
stall_cycles  out  CNT_W  cycles with StallF=1
flush_events  out  CNT_W  cycles with FlushE=1

Behaviour:
- Tag = {valid, wa3, regwrite, memtoreg, memaccess, pcwrite, ra1, ra2}. pcwrite = regwrite && wa3==PC_REG. Tags are held for stages E, M, W.
- Reset (asynchronous): all tag valids = 0 and both counters = 0. All outputs are combinational from state and therefore reset to 0. Reset mid-operation drops every in-flight tag immediately.
- Match rule: srcX matches stage S when S.valid && S.regwrite && S.wa3==srcX && srcX!=PC_REG.
- Forwarding (FWD_ENABLE=1): ForwardXE = 10 if operand matches M, else 01 if it matches W, else 00. M has priority over W.
- With FWD_ENABLE=0: forward outputs are always 00.
- ldr_stall: E is a valid load and RA1D or RA2D matches E.
- With FWD_ENABLE=0, raw_stall additionally fires when a D source matches E or M.
- pc_pend: a PC write is present in D, E or M.
- mem_stall = M.valid && M.memaccess && !mem_ready.
- Priority, highest first:
  1. mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0. Branch, ldr and pc_pend effects are deferred until release, because E is held and BranchTakenE is re-presented.
  2. BranchTakenE: FlushD=1, FlushE=1, StallF=0, StallD=0.
  3. ldr_stall / raw_stall: StallF=1, StallD=1, FlushE=1.
  4. pc_pend: StallF=1, FlushD=1.
  A PC write in W also asserts FlushD.
- Shadow advance each clock:
  - Without mem_stall: E <= D-tag (valid=0 if FlushE), M <= E, W <= M.
  - With mem_stall: E and M hold, W.valid <= 0.
  - D inputs are sampled every cycle; they are stable while StallD=1.
- Counters saturate at 2^CNT_W-1. perf_clear wins over increment.

Decomposition:
- Package arm_hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the stage_tag_t struct.
- Sub-module hazard_tag_pipe: the E/M/W shadow tag registers with hold/bubble controls.
- arm_hazard_unit holds the match logic, the priority logic and the counters.

Test Plan:
- ADD r1 in M, next instr reads RA1D=r1 reaching E -> ForwardAE=10, no stall. One cycle later with r1 in W and no M match -> ForwardAE=01.
- LDR r2 in E, D reads r2 -> StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle shows ForwardBE/AE=01 from W, and stall_cycles increments by 1.
- BranchTakenE=1 with a concurrent ldr match -> FlushD=FlushE=1, StallF=0. flush_events increments by 1.
- Load in M with mem_ready low for 3 cycles while BranchTakenE=1 -> Stall F/D/E/M high and FlushW=1 for 3 cycles, FlushE=0. On the cycle after mem_ready rises, FlushD=FlushE=1.
- MOV pc (WA3D=15) issued -> StallF=1 and FlushD=1 while it is in D/E/M. FlushD stays high in W. RA1D=15 never forwards.
- FWD_ENABLE=0 instance, ADD r3 then reader of r3 -> stalls 2 cycles, forward outputs stay 00. Assert reset mid-stall -> all outputs 0 asynchronously and counters cleared.
